// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank and its interrupt servicer: register
// map offsets and the servicer state encoding.
package gpio_pkg;

    // GPIO register map (byte offsets)
    localparam logic [7:0] GPIO_DIR          = 8'h00;
    localparam logic [7:0] GPIO_OUT          = 8'h04;
    localparam logic [7:0] GPIO_IN           = 8'h08;
    localparam logic [7:0] GPIO_INT_EN       = 8'h0C;
    localparam logic [7:0] GPIO_INT_STATUS   = 8'h10;
    localparam logic [7:0] GPIO_INT_TYPE     = 8'h14;
    localparam logic [7:0] GPIO_INT_POL      = 8'h18;
    localparam logic [7:0] GPIO_DEBOUNCE_CFG = 8'h1C;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_SETUP  = 3'd1,
        RD_ACCESS = 3'd2,
        PICK      = 3'd3,
        PRESENT   = 3'd4,
        WR_SETUP  = 3'd5,
        WR_ACCESS = 3'd6
    } svc_state_t;

endpackage

// File: rtl/gpio_irq_servicer_rr_pick32.sv
// Round-robin picker over 32 requests: rotate so that ptr becomes bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick32 (
    input  logic [31:0] req,
    input  logic [4:0]  ptr,
    output logic        any,
    output logic [4:0]  idx
);

    logic [31:0] rot;
    logic [4:0]  off;

    // Rotate right by ptr and priority-encode the lowest set bit
    always_comb begin
        rot = 32'({req, req} >> ptr);
        any = |req;
        off = 5'd0;
        // Scan downward so the lowest set bit wins
        for (int i = 31; i >= 0; i--) begin
            if (rot[i]) off = 5'(i);
        end
        idx = off + ptr;
    end

endmodule

// File: rtl/gpio_irq_servicer.sv
// APB master that services the GPIO bank interrupt: reads INT_STATUS, picks
// one pending pin round-robin, hands it to a consumer, then clears it (W1C).
module gpio_irq_servicer
    import gpio_pkg::*;
#(
    parameter logic [7:0]  ADDR_INT_STATUS = GPIO_INT_STATUS,
    parameter int unsigned TIMEOUT_CYC     = 16,
    parameter int unsigned NPINS           = 32   // rr_pick32 fixes this at 32
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        en,
    input  logic        gpio_irq,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [7:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        vec_valid,
    output logic [4:0]  vec_id,
    input  logic        vec_ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned   TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [4:0]    LAST_PIN = 5'(NPINS - 1);

    svc_state_t    state_q;
    logic [4:0]    rr_ptr_q;
    logic [31:0]   status_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          pick_any;
    logic [4:0]    pick_idx;
    logic [4:0]    next_ptr;

    rr_pick32 u_pick (
        .req (status_q),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Pointer moves just past the pin being handed off, wrapping at the top pin
    always_comb begin
        next_ptr = (vec_id == LAST_PIN) ? 5'd0 : vec_id + 5'd1;
    end

    assign busy = (state_q != IDLE);

    // Service FSM; every output is registered and set on the transition into its state
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 5'd0;
            status_q  <= 32'd0;
            tmo_cnt_q <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= 8'd0;
            PWDATA    <= 32'd0;
            vec_valid <= 1'b0;
            vec_id    <= 5'd0;
            err       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && gpio_irq) begin
                        state_q <= RD_SETUP;
                        PSEL    <= 1'b1;
                        PWRITE  <= 1'b0;
                        PADDR   <= ADDR_INT_STATUS;
                        PENABLE <= 1'b0;
                    end
                end
                RD_SETUP: begin
                    state_q   <= RD_ACCESS;
                    PENABLE   <= 1'b1;
                    tmo_cnt_q <= '0;
                end
                RD_ACCESS: begin
                    if (PREADY || (tmo_cnt_q == TMO_LAST)) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PADDR   <= 8'd0;
                        if (!PREADY || PSLVERR) begin
                            err     <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            status_q <= PRDATA;
                            state_q  <= PICK;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                PICK: begin
                    // Empty snapshot: spurious or already-cleared interrupt
                    if (pick_any) begin
                        vec_valid <= 1'b1;
                        vec_id    <= pick_idx;
                        state_q   <= PRESENT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PRESENT: begin
                    if (vec_valid && vec_ready) begin
                        vec_valid <= 1'b0;
                        rr_ptr_q  <= next_ptr;
                        PSEL      <= 1'b1;
                        PWRITE    <= 1'b1;
                        PADDR     <= ADDR_INT_STATUS;
                        PWDATA    <= 32'd1 << vec_id;
                        PENABLE   <= 1'b0;
                        state_q   <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    state_q   <= WR_ACCESS;
                    PENABLE   <= 1'b1;
                    tmo_cnt_q <= '0;
                end
                WR_ACCESS: begin
                    if (PREADY || (tmo_cnt_q == TMO_LAST)) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        PADDR   <= 8'd0;
                        PWDATA  <= 32'd0;
                        state_q <= IDLE;
                        if (!PREADY || PSLVERR) err <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
